// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit CPU front end.
// Instruction-queue entry layout, fetch FSM states and PC arithmetic.
package cpu_pkg;

  localparam int AW = 16;
  localparam int IW = 16;
  localparam logic [IW-1:0] NOP_INSTR = 16'h7000;

  typedef struct packed {
    logic [AW-1:0] pc_next;
    logic [IW-1:0] instr;
  } ifq_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ifq_state_e;

  // Word address increment; wraps 16'hFFFF -> 16'h0000 naturally.
  function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] pc);
    return pc + AW'(1);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Generic synchronous FIFO with flush; flush wins over a same-cycle push or pop.
// Callers guarantee no push when full and no pop when empty.
module ifq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_next(rd_ptr_q);
      if (push_i && !pop_i)      count_q <= count_q + CW'(1);
      else if (!push_i && pop_i) count_q <= count_q - CW'(1);
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define which words are valid.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the fetch PC, issues imem reads, buffers {pc+1, instr} for decode.
// Optional IFQ_NOP_FILL_EN presents a NOP to decode whenever the queue is empty.
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int            DEPTH    = 4,
  parameter int            MAX_OUT  = 2,
  parameter logic [AW-1:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [IW-1:0] imem_rsp_data,
  output logic          dec_valid,
  input  logic          dec_ready,
  output logic [IW-1:0] dec_instr,
  output logic [AW-1:0] dec_pc_next
);

  localparam int QCW = $clog2(DEPTH + 1);
  localparam int PCW = $clog2(MAX_OUT + 1);

  ifq_state_e    state_q;
  logic [AW-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, hold_pc_q;
  logic [IW-1:0] hold_instr_q;
  logic          epoch_q;

  ifq_entry_t     q_head, q_wdata;
  logic [QCW-1:0] q_count;
  logic           q_empty, q_full, q_push;
  logic [PCW-1:0] outstanding;
  logic           pend_epoch, pend_empty, pend_full, pend_pop;
  logic           credit, req_fire, rsp_keep, show_nop, dec_pop;

  // Queued entries plus in-flight fetches may never exceed the queue size.
  assign credit   = (int'(q_count) + int'(outstanding) < DEPTH) && !pend_full;
  assign imem_req_valid = (state_q == RUN) && credit && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire = imem_req_valid && imem_req_ready;

  // Responses tagged with an older epoch belong to a flushed fetch stream.
  assign pend_pop = imem_rsp_valid && !pend_empty;
  assign rsp_keep = pend_pop && (pend_epoch == epoch_q) && !redirect_valid;
  assign q_push   = rsp_keep && !q_full;
  assign q_wdata  = '{pc_next: pc_inc(rsp_pc_q), instr: imem_rsp_data};

`ifdef IFQ_NOP_FILL_EN
  assign show_nop = (state_q != IDLE) && (q_empty || redirect_valid);
`else
  assign show_nop = 1'b0;
`endif

  assign dec_valid   = show_nop || (!q_empty && !redirect_valid);
  assign dec_pop     = dec_valid && dec_ready && !show_nop;
  assign dec_instr   = show_nop ? NOP_INSTR : (q_empty ? hold_instr_q : q_head.instr);
  assign dec_pc_next = (show_nop || q_empty) ? hold_pc_q : q_head.pc_next;

  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
    end else begin
      if (req_fire) pc_d     = pc_inc(pc_q);
      if (rsp_keep) rsp_pc_d = pc_inc(rsp_pc_q);
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      rsp_pc_q     <= RESET_PC;
      epoch_q      <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      case (state_q)
        IDLE:    state_q <= RUN;
        RUN:     if (!credit) state_q <= HOLD;
        HOLD:    if (credit)  state_q <= RUN;
        default: state_q <= IDLE;
      endcase
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      if (redirect_valid) epoch_q <= ~epoch_q;
      if (!q_empty) begin
        hold_instr_q <= q_head.instr;
        hold_pc_q    <= q_head.pc_next;
      end
    end
  end

  ifq_fifo #(.WIDTH($bits(ifq_entry_t)), .DEPTH(DEPTH)) u_instr_q (
    .clk     (clk),
    .rst_n   (Rst),
    .push_i  (q_push),
    .pop_i   (dec_pop),
    .flush_i (redirect_valid),
    .wdata_i (q_wdata),
    .rdata_o (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  ifq_fifo #(.WIDTH(1), .DEPTH(MAX_OUT)) u_pend_q (
    .clk     (clk),
    .rst_n   (Rst),
    .push_i  (req_fire),
    .pop_i   (pend_pop),
    .flush_i (1'b0),
    .wdata_i (epoch_q),
    .rdata_o (pend_epoch),
    .full_o  (pend_full),
    .empty_o (pend_empty),
    .count_o (outstanding)
  );

endmodule
